// File: rtl/cmos_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : cmos_pixel_packer
// Description : Packs RGB565 pixel pairs from the CMOS capture path into
//               32-bit write-FIFO words, drops start-up frames, checks frame
//               geometry and forwards a pipeline-aligned frame sync.
// Revision    : 1.0 - initial release
// ============================================================================
module cmos_pixel_packer #(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIXELS   = 1280,
  parameter int V_LINES    = 720
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        sys_we,
  output logic [31:0] sys_data_in,
  output logic        vin_vs,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        geom_err
);

  localparam logic [0:0]  ST_SKIP   = 1'b0;
  localparam logic [0:0]  ST_ACTIVE = 1'b1;
  localparam logic [15:0] SKIP_CNT  = 16'(FRAME_SKIP);
  localparam logic [15:0] H_CNT     = 16'(H_PIXELS);
  localparam logic [15:0] V_CNT     = 16'(V_LINES);

  // Geometry/skip counters saturate instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [0:0]  state_q, state_d;
  logic        vsync_q, href_q;
  logic        phase_q, phase_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        mismatch_q, mismatch_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        geom_err_q, geom_err_d;

  logic vs_rise, href_rise, href_fall, pix_acc;
  logic active, enter_active, phase_eff;
  logic [15:0] pix_base;

  assign vs_rise   = cmos_vsync & ~vsync_q;
  assign href_rise = cmos_href & ~href_q;
  assign href_fall = ~cmos_href & href_q;
  assign pix_acc   = pix_valid & cmos_href;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SKIP;
    else        state_q <= state_d;
  end

  // FSM next state: leave SKIP on the frame start after FRAME_SKIP frames; ACTIVE is terminal.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_SKIP && vs_rise && skip_cnt_q == SKIP_CNT) state_d = ST_ACTIVE;
  end

  // FSM outputs: write enable gating and the sticky frame_valid flag.
  always_comb begin
    active       = (state_q == ST_ACTIVE);
    enter_active = (state_q == ST_SKIP) && (state_d == ST_ACTIVE);
    frame_valid  = active;
  end

  // Packing datapath: a line or frame start always restarts on the high half.
  always_comb begin
    phase_eff = phase_q & ~(vs_rise | href_rise);
    phase_d   = phase_eff;
    hold_d    = hold_q;
    we_d      = 1'b0;
    data_d    = data_q;
    if (active) begin
      if (pix_acc) begin
        if (!phase_eff) begin
          hold_d  = pix_data;
          phase_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          data_d  = {hold_q, pix_data};
          phase_d = 1'b0;
        end
      end else if (href_fall && !vs_rise && phase_q) begin
        // Odd-length line: flush the stranded pixel padded with zero.
        we_d    = 1'b1;
        data_d  = {hold_q, 16'h0000};
        phase_d = 1'b0;
      end
    end
  end

  // Skip, geometry and frame counters.
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if (!active && vs_rise) skip_cnt_d = sat_inc(skip_cnt_q);

    pix_base  = (vs_rise || href_fall) ? 16'd0 : pix_cnt_q;
    pix_cnt_d = pix_acc ? sat_inc(pix_base) : pix_base;

    mismatch_d = mismatch_q;
    line_cnt_d = line_cnt_q;
    if (href_fall) begin
      if (pix_cnt_q != H_CNT) mismatch_d = 1'b1;
      line_cnt_d = sat_inc(line_cnt_q);
    end
    if (vs_rise) begin
      mismatch_d = 1'b0;
      line_cnt_d = 16'd0;
    end

    geom_err_d  = geom_err_q;
    frame_cnt_d = frame_cnt_q;
    if (vs_rise && active) begin
      geom_err_d  = mismatch_q | (line_cnt_q != V_CNT);
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else if (enter_active) begin
      // No written frame precedes the first active frame start.
      geom_err_d = 1'b0;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      hold_q      <= 16'd0;
      skip_cnt_q  <= 16'd0;
      pix_cnt_q   <= 16'd0;
      line_cnt_q  <= 16'd0;
      mismatch_q  <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= 32'd0;
      frame_cnt_q <= 8'd0;
      geom_err_q  <= 1'b0;
    end else begin
      vsync_q     <= cmos_vsync;
      href_q      <= cmos_href;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      skip_cnt_q  <= skip_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      mismatch_q  <= mismatch_d;
      we_q        <= we_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      geom_err_q  <= geom_err_d;
    end
  end

  assign sys_we      = we_q;
  assign sys_data_in = data_q;
  assign vin_vs      = vsync_q;
  assign frame_cnt   = frame_cnt_q;
  assign geom_err    = geom_err_q;

endmodule
`default_nettype wire
